instr_mem_responder: RTL and testbench



---
 rtl/instr_mem_responder_pkg.sv | 23 ++
 rtl/instr_mem_responder_byte_packer.sv | 57 +++++
 rtl/instr_mem_responder.sv | 139 +++++++++++++
 tb/tb_instr_mem_responder.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/instr_mem_responder_pkg.sv
// Shared constants and types for the instruction-memory responder:
// FSM states, word/byte geometry and the fetch address check.
package instr_mem_responder_pkg;

    typedef enum logic [1:0] {
        SERVE  = 2'd0,
        LOAD   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    localparam int WORD_BYTES    = 4;
    localparam int BYTE_W        = 8;
    localparam int WORD_W        = WORD_BYTES * BYTE_W;
    localparam int DEPTH_DEFAULT = 64;

    // A fetch is rejected when the PC is not word aligned or its word index is past the store.
    function automatic logic fetch_addr_bad(input logic [WORD_W-1:0] addr, input int depth);
        logic [WORD_W-3:0] word_idx;
        word_idx = addr[WORD_W-1:2];
        return (addr[1:0] != 2'b00) || (word_idx >= (WORD_W-2)'(depth));
    endfunction

endpackage

// File: rtl/instr_mem_responder_byte_packer.sv
// Little-endian byte-to-word assembler for the program loader: a lane index
// plus an assembly register whose unfilled upper lanes are always zero.
module instr_mem_responder_byte_packer
    import instr_mem_responder_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              push,
    input  logic [BYTE_W-1:0] byte_data,
    output logic [WORD_W-1:0] word,
    output logic              word_ready,
    output logic              partial
);

    logic [1:0]        idx_r;
    logic [WORD_W-1:0] asm_r;
    logic [WORD_W-1:0] word_s;

    // Merge the incoming byte into its lane; partial reflects the index after this cycle.
    always_comb begin
        word_s = asm_r;
        if (push) begin
            case (idx_r)
                2'd0:    word_s[7:0]   = byte_data;
                2'd1:    word_s[15:8]  = byte_data;
                2'd2:    word_s[23:16] = byte_data;
                default: word_s[31:24] = byte_data;
            endcase
            word_ready = (idx_r == 2'd3);
            partial    = (idx_r != 2'd3);
        end else begin
            word_ready = 1'b0;
            partial    = (idx_r != 2'd0);
        end
    end

    assign word = word_s;

    // Lane index and assembly register; a completed word empties the register.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_r <= 2'd0;
            asm_r <= '0;
        end else if (clear) begin
            idx_r <= 2'd0;
            asm_r <= '0;
        end else if (push) begin
            idx_r <= idx_r + 2'd1;
            asm_r <= word_ready ? '0 : word_s;
        end else begin
            idx_r <= idx_r;
            asm_r <= asm_r;
        end
    end

endmodule

// File: rtl/instr_mem_responder.sv
// Instruction-fetch responder with a 1-cycle read of a DEPTH-word store and
// a byte-stream program loader that fills the store while fetch is blocked.
module instr_mem_responder
    import instr_mem_responder_pkg::*;
#(
    parameter  int DEPTH = DEPTH_DEFAULT,
    localparam int N     = WORD_W,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    input  logic [N-1:0]  req_addr,
    output logic          req_ready,
    output logic          resp_valid,
    output logic [N-1:0]  resp_instr,
    output logic          resp_err,
    input  logic          load_en,
    input  logic          byte_valid,
    input  logic [7:0]    byte_data,
    output logic          load_done,
    output logic [AW:0]   load_words,
    output logic          load_ovf
);

    state_t       state_r;
    logic [N-1:0] mem_r [DEPTH];
    logic [AW:0]  wr_ptr_r;
    logic         resp_valid_r;
    logic         resp_err_r;
    logic [N-1:0] resp_instr_r;
    logic         load_done_r;
    logic         load_ovf_r;

    logic         accept_s;
    logic         addr_bad_s;
    logic         push_s;
    logic         clear_s;
    logic         full_s;
    logic         word_ready_s;
    logic         partial_s;
    logic [N-1:0] pack_word_s;

    // Fetch acceptance and loader control decode.
    always_comb begin
        accept_s   = req_valid && (state_r == SERVE);
        addr_bad_s = fetch_addr_bad(req_addr, DEPTH);
        push_s     = byte_valid && (state_r == LOAD);
        full_s     = (wr_ptr_r == (AW+1)'(DEPTH));
        if (state_r == SERVE) begin
            clear_s = load_en;
        end else if (state_r == COMMIT) begin
            clear_s = 1'b1;
        end else begin
            clear_s = 1'b0;
        end
    end

    instr_mem_responder_byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear_s),
        .push       (push_s),
        .byte_data  (byte_data),
        .word       (pack_word_s),
        .word_ready (word_ready_s),
        .partial    (partial_s)
    );

    // Mode FSM, instruction store, fetch response and load bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= SERVE;
            wr_ptr_r     <= '0;
            resp_valid_r <= 1'b0;
            resp_err_r   <= 1'b0;
            resp_instr_r <= '0;
            load_done_r  <= 1'b0;
            load_ovf_r   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            resp_valid_r <= accept_s;
            load_done_r  <= 1'b0;
            if (accept_s) begin
                resp_err_r   <= addr_bad_s;
                resp_instr_r <= addr_bad_s ? '0 : mem_r[req_addr[AW+1:2]];
            end else begin
                resp_err_r <= 1'b0;
            end

            case (state_r)
                SERVE: begin
                    if (load_en) begin
                        state_r    <= LOAD;
                        wr_ptr_r   <= '0;
                        load_ovf_r <= 1'b0;
                    end
                end
                LOAD: begin
                    if (push_s && full_s) begin
                        load_ovf_r <= 1'b1;
                    end else if (word_ready_s) begin
                        mem_r[wr_ptr_r[AW-1:0]] <= pack_word_s;
                        wr_ptr_r                <= wr_ptr_r + 1'b1;
                    end
                    if (!load_en) begin
                        if (partial_s) begin
                            state_r <= COMMIT;
                        end else begin
                            state_r     <= SERVE;
                            load_done_r <= 1'b1;
                        end
                    end
                end
                COMMIT: begin
                    if (!full_s) begin
                        mem_r[wr_ptr_r[AW-1:0]] <= pack_word_s;
                        wr_ptr_r                <= wr_ptr_r + 1'b1;
                    end
                    state_r     <= SERVE;
                    load_done_r <= 1'b1;
                end
                default: state_r <= SERVE;
            endcase
        end
    end

    // The write pointer is also the session's word count.
    assign req_ready  = (state_r == SERVE);
    assign resp_valid = resp_valid_r;
    assign resp_instr = resp_instr_r;
    assign resp_err   = resp_err_r;
    assign load_done  = load_done_r;
    assign load_words = wr_ptr_r;
    assign load_ovf   = load_ovf_r;

endmodule

// File: tb/tb_instr_mem_responder.sv
// Directed bench for instr_mem_responder: table-driven fetch vectors plus
// hand-written load, commit, overflow and reset sequences.
module tb_instr_mem_responder;

    localparam int DEPTH = 64;
    localparam int AW    = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic [31:0]   req_addr = 32'd0;
    logic          req_ready;
    logic          resp_valid;
    logic [31:0]   resp_instr;
    logic          resp_err;
    logic          load_en = 1'b0;
    logic          byte_valid = 1'b0;
    logic [7:0]    byte_data = 8'd0;
    logic          load_done;
    logic [AW:0]   load_words;
    logic          load_ovf;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
        logic        err;
    } fvec_t;

    fvec_t      fv [16];
    logic [7:0] bq [$];

    always #5 clk = ~clk;

    instr_mem_responder #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_instr (resp_instr),
        .resp_err   (resp_err),
        .load_en    (load_en),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .load_done  (load_done),
        .load_words (load_words),
        .load_ovf   (load_ovf)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Back-to-back fetches of fv[first .. first+count-1], then the idle/hold cycle.
    task automatic run_fetch(input int first, input int count);
        for (int i = 0; i <= count; i++) begin
            @(negedge clk);
            if (i > 0) begin
                chk($sformatf("resp_valid[%0d]", first+i-1), {31'd0, resp_valid}, 32'd1);
                chk($sformatf("resp_instr[%0d]", first+i-1), resp_instr, fv[first+i-1].instr);
                chk($sformatf("resp_err[%0d]", first+i-1), {31'd0, resp_err}, {31'd0, fv[first+i-1].err});
                chk("req_ready_serve", {31'd0, req_ready}, 32'd1);
            end
            if (i < count) begin
                req_valid = 1'b1;
                req_addr  = fv[first+i].addr;
            end else begin
                req_valid = 1'b0;
            end
        end
        @(negedge clk);
        chk("idle_valid", {31'd0, resp_valid}, 32'd0);
        chk("idle_err", {31'd0, resp_err}, 32'd0);
        chk("idle_hold_instr", resp_instr, fv[first+count-1].instr);
    endtask

    // One loader session streaming bq; exp_lat is 1 without COMMIT, 2 with it.
    task automatic run_load(input int exp_lat);
        int lat;
        bit seen;
        @(negedge clk);
        load_en = 1'b1;
        byte_valid = 1'b0;
        for (int i = 0; i < bq.size(); i++) begin
            @(negedge clk);
            if (i == 0) begin
                chk("entry_clear_words", {25'd0, load_words}, 32'd0);
                chk("entry_clear_ovf", {31'd0, load_ovf}, 32'd0);
            end
            chk("ready_in_load", {31'd0, req_ready}, 32'd0);
            byte_valid = 1'b1;
            byte_data  = bq[i];
        end
        @(negedge clk);
        byte_valid = 1'b0;
        load_en    = 1'b0;
        seen = 1'b0;
        lat  = 0;
        for (int c = 1; c <= 6 && !seen; c++) begin
            @(negedge clk);
            if (load_done) begin
                seen = 1'b1;
                lat  = c;
            end
        end
        chk("load_done_seen", {31'd0, seen}, 32'd1);
        chk("load_done_latency", lat, exp_lat);
        @(negedge clk);
        chk("load_done_pulse_width", {31'd0, load_done}, 32'd0);
        chk("ready_after_load", {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        fv[0]  = '{32'h0000_0000, 32'h0000_0000, 1'b0};
        fv[1]  = '{32'h0000_0000, 32'hE1A0_0000, 1'b0};
        fv[2]  = '{32'h0000_0004, 32'hE281_1004, 1'b0};
        fv[3]  = '{32'h0000_0008, 32'h0000_0000, 1'b0};
        fv[4]  = '{32'h0000_0000, 32'h1413_1211, 1'b0};
        fv[5]  = '{32'h0000_0004, 32'h0000_1615, 1'b0};
        fv[6]  = '{32'h0000_0002, 32'h0000_0000, 1'b1};
        fv[7]  = '{32'h0000_0100, 32'h0000_0000, 1'b1};
        fv[8]  = '{32'h0000_00FC, 32'h0000_0000, 1'b0};
        fv[9]  = '{32'h0000_0104, 32'h0000_0000, 1'b1};
        fv[10] = '{32'h0000_0000, 32'h0302_0100, 1'b0};
        fv[11] = '{32'h0000_00FC, 32'hFFFE_FDFC, 1'b0};
        fv[12] = '{32'h0000_0103, 32'h0000_0000, 1'b1};
        fv[13] = '{32'h0000_0080, 32'h8382_8180, 1'b0};
        fv[14] = '{32'h0000_0000, 32'h0000_0000, 1'b0};
        fv[15] = '{32'h0000_00FC, 32'h0000_0000, 1'b0};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_instr", resp_instr, 32'd0);
        chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
        chk("rst_load_done", {31'd0, load_done}, 32'd0);
        chk("rst_load_words", {25'd0, load_words}, 32'd0);
        chk("rst_load_ovf", {31'd0, load_ovf}, 32'd0);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);

        run_fetch(0, 1);

        bq = '{8'h00, 8'h00, 8'hA0, 8'hE1, 8'h04, 8'h10, 8'h81, 8'hE2};
        run_load(1);
        chk("load1_words", {25'd0, load_words}, 32'd2);
        chk("load1_ovf", {31'd0, load_ovf}, 32'd0);

        // Bytes presented while serving must be ignored.
        byte_valid = 1'b1;
        byte_data  = 8'hAA;
        run_fetch(1, 3);
        byte_valid = 1'b0;

        bq = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16};
        run_load(2);
        chk("load2_words", {25'd0, load_words}, 32'd2);
        chk("load2_ovf", {31'd0, load_ovf}, 32'd0);
        run_fetch(4, 6);

        bq.delete();
        for (int i = 0; i < 4*DEPTH+3; i++) begin
            bq.push_back(8'(i));
        end
        run_load(2);
        chk("ovf_words", {25'd0, load_words}, 32'd64);
        chk("ovf_flag", {31'd0, load_ovf}, 32'd1);
        run_fetch(10, 4);

        // Request accepted on the load_en rising cycle returns pre-load data.
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = 32'h0000_0004;
        load_en   = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        chk("rise_resp_valid", {31'd0, resp_valid}, 32'd1);
        chk("rise_resp_instr", resp_instr, 32'h0706_0504);
        chk("rise_req_ready", {31'd0, req_ready}, 32'd0);
        chk("rise_ovf_cleared", {31'd0, load_ovf}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            byte_valid = 1'b1;
            byte_data  = 8'hA0 + 8'(i);
            @(negedge clk);
        end
        byte_valid = 1'b0;
        chk("midload_words", {25'd0, load_words}, 32'd1);
        rst     = 1'b1;
        load_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk("mrst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("mrst_load_words", {25'd0, load_words}, 32'd0);
        chk("mrst_load_ovf", {31'd0, load_ovf}, 32'd0);
        chk("mrst_resp_valid", {31'd0, resp_valid}, 32'd0);
        begin
            bit done_seen;
            done_seen = (load_done === 1'b1);
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                if (load_done === 1'b1) done_seen = 1'b1;
            end
            chk("mrst_no_load_done", {31'd0, done_seen}, 32'd0);
        end
        run_fetch(14, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
